move_controller: RTL and testbench

Turn-based game sequencer that owns the board state and drives the coordinate selector. It waits for a completed (x1,y1)->(x2,y2) selection and validates it against the board and the current player. It then commits or rejects the move, restarts the selector through its reset, and tracks turn, move count and the winner. A read port exposes the board to the display logic.

---
 rtl/move_controller.sv | 186 ++++++++++++++++++
 tb/tb_move_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/move_controller.sv
// move_controller: turn-based game sequencer.
// Owns a GRID x GRID board of 2-bit cells (0 empty, 1 player A, 2 player B).
// Waits for a completed (x1,y1)->(x2,y2) selection, validates it against the
// board and the player to move, commits or rejects it, then restarts the
// selector through sel_rst_n. Tracks turn, move count and winner.
//
// Build option: define ADJACENT_ONLY_EN to reject moves whose Chebyshev
// distance is not exactly 1 (err_code 4).
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   sel_done        selector done level
//   x1,y1,x2,y2     selected source / destination coordinates
//   sel_rst_n       registered active-low reset to the selector
//   rd_x,rd_y       display read address
//   rd_cell         combinational board read (0 when out of range)
//   turn            0 = A to move, 1 = B to move
//   move_ok         1-cycle pulse, move committed
//   move_err        1-cycle pulse, move rejected
//   err_code        last rejection reason (1 bounds, 2 not own piece,
//                   3 destination own piece, 4 not adjacent), 0 after commit
//   move_cnt        committed moves, saturating at 255
//   winner          0 none, 1 A, 2 B
module move_controller #(
    parameter int GRID = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_done,
    input  logic [3:0] x1,
    input  logic [3:0] y1,
    input  logic [3:0] x2,
    input  logic [3:0] y2,
    output logic       sel_rst_n,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic [1:0] rd_cell,
    output logic       turn,
    output logic       move_ok,
    output logic       move_err,
    output logic [2:0] err_code,
    output logic [7:0] move_cnt,
    output logic [1:0] winner
);
    typedef enum logic [2:0] {IDLE, CHECK, MOVE, REJECT, RELEASE, WAIT_CLR, OVER} state_t;

    localparam logic [4:0] GRID5 = 5'(GRID);
    localparam logic [3:0] LAST  = 4'(GRID - 1);

    state_t state, state_nx;

    // board[y][x]
    logic [GRID-1:0][GRID-1:0][1:0] board;
    logic [3:0] lx1, ly1, lx2, ly2;
    logic [2:0] code_q, chk_code;
    logic [1:0] player, src_cell, dst_cell;
    logic       win_now;

    logic       turn_d, move_ok_d, move_err_d, sel_rst_n_d;
    logic [2:0] err_code_d;
    logic [7:0] move_cnt_d;
    logic [1:0] winner_d;

    // Mux-based cell read; any coordinate outside the grid reads as empty.
    function automatic logic [1:0] cell_at(input logic [GRID-1:0][GRID-1:0][1:0] b,
                                           input logic [3:0] cx, input logic [3:0] cy);
        logic [1:0] r;
        r = 2'd0;
        for (int j = 0; j < GRID; j++)
            for (int i = 0; i < GRID; i++)
                if (cx == 4'(i) && cy == 4'(j)) r = b[j][i];
        return r;
    endfunction

    assign player   = turn ? 2'd2 : 2'd1;
    assign src_cell = cell_at(board, lx1, ly1);
    assign dst_cell = cell_at(board, lx2, ly2);
    assign rd_cell  = cell_at(board, rd_x, rd_y);

`ifdef ADJACENT_ONLY_EN
    logic [3:0] dx, dy;
    assign dx = (lx2 > lx1) ? lx2 - lx1 : lx1 - lx2;
    assign dy = (ly2 > ly1) ? ly2 - ly1 : ly1 - ly2;
`endif

    // Rule evaluation on the latched coordinates; first failure wins.
    always_comb begin
        chk_code = 3'd0;
        if ({1'b0, lx1} >= GRID5 || {1'b0, ly1} >= GRID5 ||
            {1'b0, lx2} >= GRID5 || {1'b0, ly2} >= GRID5)
            chk_code = 3'd1;
        else if (src_cell != player)
            chk_code = 3'd2;
        else if (dst_cell == player)
            chk_code = 3'd3;
`ifdef ADJACENT_ONLY_EN
        else if (((dx > dy) ? dx : dy) != 4'd1)
            chk_code = 3'd4;
`endif
    end

    assign win_now = (!turn && ly2 == LAST) || (turn && ly2 == 4'd0);

    // State register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (sel_done) state_nx = CHECK;
            CHECK:    state_nx = (chk_code == 3'd0) ? MOVE : REJECT;
            MOVE:     state_nx = RELEASE;
            REJECT:   state_nx = RELEASE;
            RELEASE:  state_nx = WAIT_CLR;
            WAIT_CLR: if (!sel_done) state_nx = (winner != 2'd0) ? OVER : IDLE;
            OVER:     state_nx = OVER;
            default:  state_nx = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        move_ok_d   = (state == MOVE);
        move_err_d  = (state == REJECT);
        sel_rst_n_d = (state != RELEASE);
        err_code_d  = err_code;
        move_cnt_d  = move_cnt;
        winner_d    = winner;
        turn_d      = turn;
        if (state == MOVE) begin
            err_code_d = 3'd0;
            if (move_cnt != 8'hFF) move_cnt_d = move_cnt + 8'd1;
            if (win_now) winner_d = player;
            else         turn_d   = ~turn;
        end else if (state == REJECT) begin
            err_code_d = code_q;
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            move_ok   <= 1'b0;
            move_err  <= 1'b0;
            sel_rst_n <= 1'b1;
            err_code  <= 3'd0;
            move_cnt  <= 8'd0;
            winner    <= 2'd0;
            turn      <= 1'b0;
        end else begin
            move_ok   <= move_ok_d;
            move_err  <= move_err_d;
            sel_rst_n <= sel_rst_n_d;
            err_code  <= err_code_d;
            move_cnt  <= move_cnt_d;
            winner    <= winner_d;
            turn      <= turn_d;
        end

    // Selection latch and rejection code
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            lx1 <= 4'd0; ly1 <= 4'd0; lx2 <= 4'd0; ly2 <= 4'd0;
            code_q <= 3'd0;
        end else begin
            if (state == IDLE && sel_done) begin
                lx1 <= x1; ly1 <= y1; lx2 <= x2; ly2 <= y2;
            end
            if (state == CHECK) code_q <= chk_code;
        end

    // Board: src and dst are distinct here because CHECK rejected src==dst.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int j = 0; j < GRID; j++)
                for (int i = 0; i < GRID; i++)
                    board[j][i] <= (j == 0) ? 2'd1 : (j == GRID - 1) ? 2'd2 : 2'd0;
        end else if (state == MOVE) begin
            for (int j = 0; j < GRID; j++)
                for (int i = 0; i < GRID; i++)
                    if (lx2 == 4'(i) && ly2 == 4'(j))      board[j][i] <= player;
                    else if (lx1 == 4'(i) && ly1 == 4'(j)) board[j][i] <= 2'd0;
        end
endmodule

// File: tb/tb_move_controller.sv
module tb_move_controller;
    logic       clk, rst, sel_done, sel_rst_n, turn, move_ok, move_err;
    logic [3:0] x1, y1, x2, y2, rd_x, rd_y;
    logic [1:0] rd_cell, winner;
    logic [2:0] err_code;
    logic [7:0] move_cnt;

    int tests = 0, failed = 0;

    move_controller #(.GRID(8)) dut (
        .clk(clk), .rst(rst), .sel_done(sel_done),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .sel_rst_n(sel_rst_n), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell),
        .turn(turn), .move_ok(move_ok), .move_err(move_err), .err_code(err_code),
        .move_cnt(move_cnt), .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x1, y1, x2, y2;
        logic       ok;
        int         code;
        int         trn;
        int         cnt;
        int         win;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic rd(input string nm, input int x, input int y, input int exp);
        rd_x = 4'(x); rd_y = 4'(y);
        #1;
        chk(nm, int'(rd_cell), exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; sel_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Raise sel_done with a selection and watch the handshake. hold==0 drops
    // sel_done as soon as sel_rst_n goes low; otherwise it is held for hold
    // sample points. Sample n is the negedge after edge E(n-1).
    task automatic run_move(input int ax1, input int ay1, input int ax2, input int ay2,
                            input int hold,
                            output int oks, output int errs, output int pulse_at,
                            output int code_at, output int lows, output int low_at,
                            output int both);
        int last;
        oks = 0; errs = 0; pulse_at = -1; code_at = -1; lows = 0; low_at = -1; both = 0;
        @(negedge clk);
        x1 = 4'(ax1); y1 = 4'(ay1); x2 = 4'(ax2); y2 = 4'(ay2);
        sel_done = 1'b1;
        last = (hold > 0 ? hold : 0) + 8;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            if (move_ok)  begin oks++;  pulse_at = n; code_at = int'(err_code); end
            if (move_err) begin errs++; pulse_at = n; code_at = int'(err_code); end
            if (move_ok && move_err) both++;
            if (!sel_rst_n) begin lows++; if (low_at < 0) low_at = n; end
            if (hold == 0 && !sel_rst_n) sel_done = 1'b0;
            if (hold > 0 && n == hold) sel_done = 1'b0;
        end
    endtask

    initial begin
        int oks, errs, pat, cat, lows, lat, both, ptrn;
        rst = 1'b0; sel_done = 1'b0;
        x1 = 0; y1 = 0; x2 = 0; y2 = 0; rd_x = 0; rd_y = 0;

        // x1 y1 x2 y2 ok code turn cnt win
        vt[0]  = '{4'd2, 4'd0, 4'd2, 4'd1, 1'b1, 0, 1, 1, 0};
        vt[1]  = '{4'd2, 4'd1, 4'd2, 4'd2, 1'b0, 2, 1, 1, 0};
        vt[2]  = '{4'd2, 4'd1, 4'd9, 4'd2, 1'b0, 1, 1, 1, 0};
        vt[3]  = '{4'd5, 4'd7, 4'd5, 4'd7, 1'b0, 3, 1, 1, 0};
        vt[4]  = '{4'd5, 4'd7, 4'd5, 4'd6, 1'b1, 0, 0, 2, 0};
        vt[5]  = '{4'd2, 4'd1, 4'd2, 4'd2, 1'b1, 0, 1, 3, 0};
        vt[6]  = '{4'd5, 4'd6, 4'd5, 4'd5, 1'b1, 0, 0, 4, 0};
        vt[7]  = '{4'd2, 4'd2, 4'd2, 4'd3, 1'b1, 0, 1, 5, 0};
        vt[8]  = '{4'd5, 4'd5, 4'd5, 4'd4, 1'b1, 0, 0, 6, 0};
        vt[9]  = '{4'd2, 4'd3, 4'd2, 4'd4, 1'b1, 0, 1, 7, 0};
        vt[10] = '{4'd5, 4'd4, 4'd5, 4'd3, 1'b1, 0, 0, 8, 0};
        vt[11] = '{4'd2, 4'd4, 4'd2, 4'd5, 1'b1, 0, 1, 9, 0};
        vt[12] = '{4'd5, 4'd3, 4'd5, 4'd2, 1'b1, 0, 0, 10, 0};
        vt[13] = '{4'd2, 4'd5, 4'd2, 4'd6, 1'b1, 0, 1, 11, 0};
        vt[14] = '{4'd5, 4'd2, 4'd5, 4'd1, 1'b1, 0, 0, 12, 0};
        vt[15] = '{4'd2, 4'd6, 4'd2, 4'd7, 1'b1, 0, 0, 13, 1};

        // Reset state
        #12 rst = 1'b1;
        @(negedge clk);
        rd("rst_cell_3_0", 3, 0, 1);
        rd("rst_cell_3_7", 3, 7, 2);
        rd("rst_cell_3_3", 3, 3, 0);
        rd("rst_cell_oob", 9, 0, 0);
        chk("rst_turn", int'(turn), 0);
        chk("rst_cnt", int'(move_cnt), 0);
        chk("rst_sel_rst_n", int'(sel_rst_n), 1);
        chk("rst_winner", int'(winner), 0);
        chk("rst_pulses", int'(move_ok) + int'(move_err), 0);
        chk("rst_err_code", int'(err_code), 0);

        // Table-driven game ending with A landing on row 7
        ptrn = 0;
        foreach (vt[k]) begin
            run_move(vt[k].x1, vt[k].y1, vt[k].x2, vt[k].y2, 0,
                     oks, errs, pat, cat, lows, lat, both);
            chk($sformatf("v%0d_ok", k), oks, vt[k].ok ? 1 : 0);
            chk($sformatf("v%0d_err", k), errs, vt[k].ok ? 0 : 1);
            chk($sformatf("v%0d_pulse_at", k), pat, 3);
            chk($sformatf("v%0d_code", k), cat, vt[k].code);
            chk($sformatf("v%0d_held_code", k), int'(err_code), vt[k].code);
            chk($sformatf("v%0d_low_cnt", k), lows, 1);
            chk($sformatf("v%0d_low_at", k), lat, 4);
            chk($sformatf("v%0d_both", k), both, 0);
            chk($sformatf("v%0d_turn", k), int'(turn), vt[k].trn);
            chk($sformatf("v%0d_cnt", k), int'(move_cnt), vt[k].cnt);
            chk($sformatf("v%0d_winner", k), int'(winner), vt[k].win);
            if (vt[k].ok) begin
                rd($sformatf("v%0d_dst", k), vt[k].x2, vt[k].y2, ptrn + 1);
                rd($sformatf("v%0d_src", k), vt[k].x1, vt[k].y1, 0);
            end else if (vt[k].code == 2) begin
                rd($sformatf("v%0d_src_kept", k), vt[k].x1, vt[k].y1, 1);
            end
            ptrn = vt[k].trn;
        end

        // Game over: requests ignored, board frozen
        run_move(3, 0, 3, 1, 10, oks, errs, pat, cat, lows, lat, both);
        chk("over_ok", oks, 0);
        chk("over_err", errs, 0);
        chk("over_low", lows, 0);
        chk("over_cnt", int'(move_cnt), 13);
        chk("over_turn", int'(turn), 0);
        rd("over_cell_3_1", 3, 1, 0);
        rd("over_cell_3_0", 3, 0, 1);

        do_reset();
        rd("rst2_cell_2_7", 2, 7, 2);
        rd("rst2_cell_2_0", 2, 0, 1);
        rd("rst2_cell_2_6", 2, 6, 0);
        chk("rst2_winner", int'(winner), 0);
        chk("rst2_cnt", int'(move_cnt), 0);

        // Long-distance move by B
        run_move(3, 0, 3, 1, 0, oks, errs, pat, cat, lows, lat, both);
        chk("adj_a_ok", oks, 1);
        run_move(5, 7, 5, 4, 0, oks, errs, pat, cat, lows, lat, both);
`ifdef ADJACENT_ONLY_EN
        chk("adj_b_err", errs, 1);
        chk("adj_b_code", cat, 4);
        chk("adj_b_turn", int'(turn), 1);
        chk("adj_b_cnt", int'(move_cnt), 1);
        rd("adj_b_src", 5, 7, 2);
`else
        chk("adj_b_ok", oks, 1);
        chk("adj_b_code", cat, 0);
        chk("adj_b_turn", int'(turn), 0);
        chk("adj_b_cnt", int'(move_cnt), 2);
        rd("adj_b_dst", 5, 4, 2);
`endif

        // sel_done held long after a commit: single commit
        do_reset();
        run_move(1, 0, 1, 1, 20, oks, errs, pat, cat, lows, lat, both);
        chk("hold_ok", oks, 1);
        chk("hold_err", errs, 0);
        chk("hold_low", lows, 1);
        chk("hold_cnt", int'(move_cnt), 1);
        chk("hold_turn", int'(turn), 1);

        // Reset while in CHECK drops the move
        do_reset();
        x1 = 4'd1; y1 = 4'd0; x2 = 4'd1; y2 = 4'd1;
        sel_done = 1'b1;
        @(negedge clk);
        rst = 1'b0; sel_done = 1'b0;
        oks = 0; errs = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            oks += int'(move_ok); errs += int'(move_err);
        end
        rst = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            oks += int'(move_ok); errs += int'(move_err);
        end
        chk("rstchk_ok", oks, 0);
        chk("rstchk_err", errs, 0);
        chk("rstchk_cnt", int'(move_cnt), 0);
        chk("rstchk_turn", int'(turn), 0);
        rd("rstchk_cell_1_1", 1, 1, 0);
        rd("rstchk_cell_1_0", 1, 0, 1);
        run_move(1, 0, 1, 1, 0, oks, errs, pat, cat, lows, lat, both);
        chk("rstchk_after_ok", oks, 1);
        chk("rstchk_after_cnt", int'(move_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Hard bound on total run time
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
